fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage that owns the program counter and the IF/ID pipeline register. It drives the PC into the combinational, byte-addressed, big-endian instruction memory and captures the returned 32-bit word with its PC into IF/ID for decode. It handles hazard stalls, jump/branch redirects with flush, and halts cleanly when the PC leaves the populated memory range.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
MEM_BYTES, 36, size of instruction memory in bytes; a fetch is legal only when pc+4 <= MEM_BYTES.
NOP_WORD, 32'h0000_0000, instruction word placed in IF/ID for bubbles.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  hold PC and IF/ID (load-use hazard from decode).
redirect  input  1  take redirect_pc next cycle (jump/branch/jr resolved downstream).
redirect_pc  input  32  target byte address.
inst_code  input  32  instruction word returned by instruction memory for pc_out.
pc_out  output  32  current fetch address to instruction memory (equals PC register, no logic).
if_id_inst  output  32  registered instruction for decode.
if_id_pc  output  32  PC of if_id_inst.
if_id_pc_plus4  output  32  if_id_pc + 4.
if_id_valid  output  1  IF/ID holds a real instruction.
halted  output  1  fetch is stopped (PC out of range).

Behaviour:
- Reset (synchronous, active-high, wins over everything): PC=RESET_PC, if_id_inst=NOP_WORD, if_id_pc=0, if_id_pc_plus4=0, if_id_valid=0, halted=0, state=RUN. Reset asserted mid-stall or mid-redirect discards that request.
- States: RUN, HALT. halted=1 iff state==HALT.
- Per-cycle priority: reset > redirect > stall > normal fetch.
- RUN, normal fetch, in range (PC+4 <= MEM_BYTES): if_id_inst<=inst_code, if_id_pc<=PC, if_id_pc_plus4<=PC+4, if_id_valid<=1, PC<=PC+4. Latency: a word appears in IF/ID one clock after its PC is on pc_out.
- RUN, out of range: IF/ID <= bubble (NOP_WORD, valid=0), PC held, state->HALT. inst_code is ignored.
- Stall (no redirect): PC and all IF/ID outputs hold their values, including valid.
- Redirect (in any state, overrides stall): PC<=redirect_pc, IF/ID <= bubble (flushes the wrong-path word), state->RUN. The redirect target is fetched the following cycle.
- HALT: PC and bubble held; stall ignored; only redirect or reset leave HALT.
- PC arithmetic is 32-bit modulo 2^32; wrap-around falls out of range and enters HALT.
- if_id_pc and if_id_pc_plus4 are updated together; if_id_pc_plus4 is always if_id_pc+4 when valid=1.

Optional Feature:
Macro FETCH_ALIGN_CHECK_EN. When defined: adds output misalign_err (1 bit, reset 0). A redirect with redirect_pc[1:0] != 0 loads no PC; instead it inserts a bubble, sets misalign_err=1 (sticky until reset), and enters HALT. When undefined: no misalign_err port; redirect_pc is used as-is and low bits are not checked.

Decomposition:
- Shared package fetch_pkg: state encoding (FETCH_RUN, FETCH_HALT), NOP_WORD constant, INST_W=32 / ADDR_W=32 widths, reused by decode and hazard logic.
- One natural sub-module: if_id_reg, holding the IF/ID register with load/hold/flush controls. The PC/state logic stays in fetch_unit.

Test Plan:
- Reset, then run with memory holding 8d61000c, 3d020008 at 0x0/0x4 -> cycle 1: if_id_inst=8d61000c, if_id_pc=0, valid=1, pc_out=4; cycle 2: 3d020008, if_id_pc=4.
- stall held 3 cycles at pc_out=8 -> pc_out stays 8, IF/ID stays 3d020008/pc 4 for all 3 cycles; after release, 68281000 with if_id_pc=8.
- redirect=1, redirect_pc=0x14, asserted together with stall=1 while pc_out=0x10 -> next cycle valid=0, inst=0, pc_out=0x14; following cycle if_id_inst=aca40004, if_id_pc=0x14.
- Free run to the end of memory -> last valid fetch at pc 0x20; at pc_out=0x24, bubble inserted and halted=1; stall toggling has no effect; redirect to 0x0 -> halted=0, 8d61000c fetched again.
- reset asserted in the same cycle as redirect to 0x18 -> pc_out=RESET_PC, valid=0, redirect ignored.
- With FETCH_ALIGN_CHECK_EN defined, redirect_pc=0x0A -> misalign_err=1, halted=1, valid=0, pc_out unchanged. Without the macro -> pc_out=0x0A.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage widths, state encoding and bubble word.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [INST_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and flush-to-bubble.
module if_id_reg
    import fetch_pkg::INST_W;
    import fetch_pkg::ADDR_W;
#(
    parameter logic [INST_W-1:0] NOP_WORD = fetch_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              flush,
    input  logic [INST_W-1:0] inst_code,
    input  logic [ADDR_W-1:0] pc,
    output logic [INST_W-1:0] if_id_inst,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_pc_plus4,
    output logic              if_id_valid
);

    // A flush only kills the word; the PC fields keep their last valid value.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_inst     <= NOP_WORD;
            if_id_pc       <= '0;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
        end else if (flush) begin
            if_id_inst  <= NOP_WORD;
            if_id_valid <= 1'b0;
        end else if (load) begin
            if_id_inst     <= inst_code;
            if_id_pc       <= pc;
            if_id_pc_plus4 <= pc + ADDR_W'(4);
            if_id_valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, run/halt state and IF/ID for fetch; optional FETCH_ALIGN_CHECK_EN.
module fetch_unit
    import fetch_pkg::INST_W;
    import fetch_pkg::ADDR_W;
    import fetch_pkg::fetch_state_t;
    import fetch_pkg::FETCH_RUN;
    import fetch_pkg::FETCH_HALT;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                MEM_BYTES = 36,
    parameter logic [INST_W-1:0] NOP_WORD  = fetch_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic [INST_W-1:0] inst_code,
    output logic [ADDR_W-1:0] pc_out,
    output logic [INST_W-1:0] if_id_inst,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_pc_plus4,
    output logic              if_id_valid,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic              misalign_err,
`endif
    output logic              halted
);

    logic [ADDR_W-1:0] pc;
    fetch_state_t      state;
    logic [ADDR_W:0]   pc_end;
    logic              in_range;
    logic              run_fetch;
    logic              redirect_bad;

    // One extra bit so a PC near 2^32 wraps out of range instead of back in.
    assign pc_end    = {1'b0, pc} + (ADDR_W+1)'(4);
    assign in_range  = pc_end <= (ADDR_W+1)'(MEM_BYTES);
    assign run_fetch = (state == FETCH_RUN) && !stall && !redirect;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_bad = redirect && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset)
            misalign_err <= 1'b0;
        else if (redirect_bad)
            misalign_err <= 1'b1;
    end
`else
    assign redirect_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            state <= FETCH_RUN;
        end else if (redirect) begin
            if (redirect_bad) begin
                state <= FETCH_HALT;
            end else begin
                pc    <= redirect_pc;
                state <= FETCH_RUN;
            end
        end else if (run_fetch) begin
            if (in_range)
                pc <= pc + ADDR_W'(4);
            else
                state <= FETCH_HALT;
        end
    end

    assign pc_out = pc;
    assign halted = (state == FETCH_HALT);

    if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id_reg (
        .clk            (clk),
        .reset          (reset),
        .load           (run_fetch && in_range),
        .flush          (redirect || (run_fetch && !in_range)),
        .inst_code      (inst_code),
        .pc             (pc),
        .if_id_inst     (if_id_inst),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed plus random checks of fetch_unit against a behavioural model.
module tb_fetch_unit;

    localparam int MEM_BYTES = 36;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst_code;
    logic [31:0] pc_out;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        halted;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_b [0:MEM_BYTES-1];

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_ipc;
    logic        m_valid;
    logic        m_halt;
    logic        m_mis;
    logic        model_ok = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .MEM_BYTES (MEM_BYTES),
        .NOP_WORD  (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .inst_code      (inst_code),
        .pc_out         (pc_out),
        .if_id_inst     (if_id_inst),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
`ifdef FETCH_ALIGN_CHECK_EN
        .misalign_err   (misalign_err),
`endif
        .halted         (halted)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        longint ea = longint'(a);
        if (ea + 4 <= MEM_BYTES)
            return {mem_b[ea], mem_b[ea+1], mem_b[ea+2], mem_b[ea+3]};
        return 32'hDEAD_BEEF;
    endfunction

    always_comb inst_code = word_at(pc_out);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour expressed directly from the fetch rules.
    task automatic model_step(input logic r, input logic rd, input logic [31:0] rpc, input logic st);
        logic align_bad;
`ifdef FETCH_ALIGN_CHECK_EN
        align_bad = (rpc % 4) != 0;
`else
        align_bad = 1'b0;
`endif
        if (r) begin
            m_pc = 0; m_inst = 0; m_ipc = 0; m_valid = 0; m_halt = 0; m_mis = 0;
        end else if (rd) begin
            m_inst = 0; m_valid = 0;
            if (align_bad) begin
                m_halt = 1; m_mis = 1;
            end else begin
                m_pc = rpc; m_halt = 0;
            end
        end else if (m_halt || st) begin
        end else if (longint'(m_pc) + 4 <= MEM_BYTES) begin
            m_inst = word_at(m_pc); m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 4;
        end else begin
            m_inst = 0; m_valid = 0; m_halt = 1;
        end
    endtask

    task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic st);
        reset = r; redirect = rd; redirect_pc = rpc; stall = st;
        @(posedge clk);
        model_step(r, rd, rpc, st);
        if (r) model_ok = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            check("pc_out", pc_out, m_pc);
            check("halted", 32'(halted), 32'(m_halt));
            check("valid", 32'(if_id_valid), 32'(m_valid));
            check("inst", if_id_inst, m_inst);
            if (m_valid) begin
                check("if_id_pc", if_id_pc, m_ipc);
                check("pc_plus4", if_id_pc_plus4, m_ipc + 32'd4);
            end
`ifdef FETCH_ALIGN_CHECK_EN
            check("misalign_err", 32'(misalign_err), 32'(m_mis));
`endif
        end
    end

    initial begin
        logic [31:0] words [0:8];
        words = '{32'h8d61000c, 32'h3d020008, 32'h68281000, 32'h20420001, 32'h10000003,
                  32'haca40004, 32'h00851020, 32'h08000000, 32'hac410010};
        for (int i = 0; i < 9; i++)
            for (int b = 0; b < 4; b++)
                mem_b[i*4+b] = words[i][31-8*b -: 8];
        reset = 1; stall = 0; redirect = 0; redirect_pc = 0;

        step(1, 0, 0, 0);
        check("lit_reset_pc", pc_out, 32'h0);
        check("lit_reset_valid", 32'(if_id_valid), 32'h0);
        check("lit_reset_inst", if_id_inst, 32'h0);
        step(0, 0, 0, 0);
        check("lit_c1_inst", if_id_inst, 32'h8d61000c);
        check("lit_c1_pc", if_id_pc, 32'h0);
        check("lit_c1_pcout", pc_out, 32'h4);
        step(0, 0, 0, 0);
        check("lit_c2_inst", if_id_inst, 32'h3d020008);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            check("lit_stall_pc", pc_out, 32'h8);
            check("lit_stall_inst", if_id_inst, 32'h3d020008);
            check("lit_stall_ipc", if_id_pc, 32'h4);
        end
        step(0, 0, 0, 0);
        check("lit_release_inst", if_id_inst, 32'h68281000);
        check("lit_release_ipc", if_id_pc, 32'h8);
        step(0, 0, 0, 0);
        step(0, 1, 32'h14, 1);
        check("lit_redir_valid", 32'(if_id_valid), 32'h0);
        check("lit_redir_pc", pc_out, 32'h14);
        step(0, 0, 0, 0);
        check("lit_redir_inst", if_id_inst, 32'haca40004);
        check("lit_redir_ipc", if_id_pc, 32'h14);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("lit_last_ipc", if_id_pc, 32'h20);
        check("lit_last_plus4", if_id_pc_plus4, 32'h24);
        step(0, 0, 0, 0);
        check("lit_halt", 32'(halted), 32'h1);
        check("lit_halt_pc", pc_out, 32'h24);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1'(i));
        check("lit_halt_hold", 32'(halted), 32'h1);
        step(0, 1, 32'h0, 0);
        check("lit_unhalt", 32'(halted), 32'h0);
        step(0, 0, 0, 0);
        check("lit_refetch", if_id_inst, 32'h8d61000c);
        step(1, 1, 32'h18, 0);
        check("lit_reset_redir_pc", pc_out, 32'h0);
        step(0, 0, 0, 0);
        step(0, 1, 32'h0A, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("lit_misalign_err", 32'(misalign_err), 32'h1);
        check("lit_misalign_pc", pc_out, 32'h4);
`else
        check("lit_unaligned_pc", pc_out, 32'h0A);
`endif
        step(0, 0, 0, 0);
        step(0, 1, 32'hFFFF_FFFC, 0);
        step(0, 0, 0, 0);
        check("lit_wrap_halt", 32'(halted), 32'h1);

        for (int i = 0; i < 600; i++) begin
            logic        r, rd, st;
            logic [31:0] rpc;
            r  = ($urandom_range(0, 59) == 0);
            rd = ($urandom_range(0, 7) == 0);
            st = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0, 1:    rpc = 32'($urandom_range(0, 9)) * 4;
                2:       rpc = 32'($urandom_range(0, 40));
                default: rpc = 32'hFFFF_FFFC;
            endcase
            step(r, rd, rpc, st);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
